// File: rtl/mask_decode_16_if.sv
// Handshake bundle for mask_decode_16: input mask stream, decoded output stream
// and the saturating error counter.
interface mask_decode_16_if;
  logic [15:0] in_mask;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_idx;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_count;

  modport master (
    output in_mask, in_valid, out_ready,
    input  in_ready, out_idx, out_err, out_valid, err_count
  );

  modport slave (
    input  in_mask, in_valid, out_ready,
    output in_ready, out_idx, out_err, out_valid, err_count
  );
endinterface

// File: rtl/mask_decode_16.sv
// Thermometer-mask to index decoder with a two-stage valid/ready pipeline and a
// saturating count of delivered error words.
module mask_decode_16 #(
  parameter bit FROM_MSB  = 1'b1,
  parameter bit DIAG_ONES = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  mask_decode_16_if.slave bus
);

  logic [15:0] mask_p1_q, mask_p1_d;
  logic        vld_p1_q, vld_p1_d;
  logic [3:0]  idx_p2_q, idx_p2_d;
  logic        err_p2_q, err_p2_d;
  logic        vld_p2_q, vld_p2_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        en1, en2, xfer_in, xfer_out;
  logic [4:0]  dec;

  // Returns {err, idx}; the mask is normalised to fill-from-bit-0 first.
  function automatic logic [4:0] decode(input logic [15:0] raw);
    logic [15:0] m;
    logic [16:0] ext;
    logic [4:0]  n;
    logic [4:0]  nm1;
    logic        legal;
    logic [3:0]  idx;
    logic        err;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      m[i] = FROM_MSB ? raw[15-i] : raw[i];
    end
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, m[i]};
    end
    ext   = {1'b0, m};
    legal = ((ext & (ext + 17'd1)) == 17'd0);
    nm1   = n - 5'd1;
    if (DIAG_ONES) begin
      idx = (n == 5'd0) ? 4'd0 : nm1[3:0];
      err = (n == 5'd0) || !legal;
    end else begin
      idx = (n == 5'd16) ? 4'd15 : n[3:0];
      err = (n == 5'd16) || !legal;
    end
    return {err, idx};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_comb begin
    en2      = !vld_p2_q || bus.out_ready;
    en1      = !vld_p1_q || en2;
    xfer_in  = rst_n && bus.in_valid && en1;
    xfer_out = vld_p2_q && bus.out_ready;
    dec      = decode(mask_p1_q);

    mask_p1_d = xfer_in ? bus.in_mask : mask_p1_q;
    vld_p1_d  = en1 ? xfer_in : vld_p1_q;
    vld_p2_d  = en2 ? vld_p1_q : vld_p2_q;
    // Data only moves with a valid word, so stale S1 contents never reach S2.
    idx_p2_d  = (en2 && vld_p1_q) ? dec[3:0] : idx_p2_q;
    err_p2_d  = (en2 && vld_p1_q) ? dec[4]   : err_p2_q;
    err_cnt_d = (xfer_out && err_p2_q) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  // Stage 1: captured mask
  always_ff @(posedge clk) begin
    mask_p1_q <= mask_p1_d;
  end

  // Stage 1 valid, stage 2 result and error counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      idx_p2_q  <= 4'd0;
      err_p2_q  <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      idx_p2_q  <= idx_p2_d;
      err_p2_q  <= err_p2_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = rst_n && en1;
  assign bus.out_idx   = idx_p2_q;
  assign bus.out_err   = err_p2_q;
  assign bus.out_valid = vld_p2_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_mask_decode_16.sv
// Bench for mask_decode_16: all four parameter combinations run side by side on
// a shared handshake, each checked against a rule-level decode model.
module tb_mask_decode_16;

  typedef struct packed {
    logic [19:0] e;
    logic [31:0] stamp;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] mask_a [4];
  logic        rdy_a  [4];
  logic [3:0]  idx_a  [4];
  logic        err_a  [4];
  logic        ov_a   [4];
  logic [7:0]  cnt_a  [4];

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;
  bit   prev_stall = 1'b0;
  ent_t q[$];
  int   errm [4];
  logic [4:0] pword [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mask_decode_16_if ifc ();
    assign ifc.in_mask   = mask_a[g];
    assign ifc.in_valid  = in_valid;
    assign ifc.out_ready = out_ready;
    assign rdy_a[g] = ifc.in_ready;
    assign idx_a[g] = ifc.out_idx;
    assign err_a[g] = ifc.out_err;
    assign ov_a[g]  = ifc.out_valid;
    assign cnt_a[g] = ifc.err_count;
    mask_decode_16 #(.FROM_MSB(g >= 2), .DIAG_ONES((g % 2) == 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );
  end

  function automatic int ones(input logic [15:0] m);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m[i]);
    return c;
  endfunction

  function automatic logic [15:0] therm(input int n, input bit msb);
    logic [31:0] v;
    if (msb) v = (32'hFFFF << (16 - n)) & 32'hFFFF;
    else     v = (32'h1 << n) - 32'h1;
    return v[15:0];
  endfunction

  function automatic logic [15:0] enc(input int k, input int g);
    return therm(((g % 2) == 1) ? k + 1 : k, g >= 2);
  endfunction

  function automatic logic [4:0] ref_dec(input logic [15:0] m, input int g);
    int  n = ones(m);
    bit  legal = (m == therm(n, g >= 2));
    int  idx;
    bit  err;
    if ((g % 2) == 1) begin
      idx = (n == 0) ? 0 : n - 1;
      err = !legal || (n == 0);
    end else begin
      idx = (n > 15) ? 15 : n;
      err = !legal || (n == 16);
    end
    return {err, 4'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(output bit acc);
    ent_t ent;
    bit   in_rst;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    in_rst = !rst_n;
    for (int g = 0; g < 4; g++)
      chk("in_ready", 32'(rdy_a[g]), 32'(rst_n && (q.size() < 2 || out_ready)));
    if (prev_stall) begin
      for (int g = 0; g < 4; g++) begin
        chk("stall_valid", 32'(ov_a[g]), 32'd1);
        chk("stall_word", 32'({err_a[g], idx_a[g]}), 32'(pword[g]));
      end
    end
    if (in_rst) begin
      q.delete();
      for (int g = 0; g < 4; g++) errm[g] = 0;
      prev_stall = 1'b0;
    end else begin
      if (ov_a[0] && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(ov_a[0]), 32'd0);
        end else begin
          ent = q.pop_front();
          for (int g = 0; g < 4; g++) begin
            chk("out_word", 32'({err_a[g], idx_a[g]}), 32'(ent.e[g*5 +: 5]));
            if (ent.e[g*5+4] && errm[g] < 255) errm[g]++;
          end
          if (lat_chk) chk("latency", 32'(cyc) - ent.stamp, 32'd2);
        end
      end
      acc = in_valid && rdy_a[0];
      if (acc) begin
        for (int g = 0; g < 4; g++) ent.e[g*5 +: 5] = ref_dec(mask_a[g], g);
        ent.stamp = 32'(cyc);
        q.push_back(ent);
      end
      prev_stall = ov_a[0] && !out_ready;
      for (int g = 0; g < 4; g++) pword[g] = {err_a[g], idx_a[g]};
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("err_count", 32'(cnt_a[g]), 32'(errm[g]));
      if (in_rst) begin
        chk("rst_valid", 32'(ov_a[g]), 32'd0);
        chk("rst_idx", 32'(idx_a[g]), 32'd0);
        chk("rst_err", 32'(err_a[g]), 32'd0);
      end
    end
  endtask

  task automatic do_reset();
    bit acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    cycle(acc);
    cycle(acc);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    bit acc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle(acc);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int w;
    int it;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) mask_a[g] = 16'h0;

    // Reset state and ready right after release
    do_reset();
    for (int g = 0; g < 4; g++) chk("reset_cnt", 32'(cnt_a[g]), 32'd0);
    cycle(acc);

    // Round trip: encoder pattern k=0..15 back to back
    out_ready = 1'b1;
    lat_chk = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int g = 0; g < 4; g++) mask_a[g] = enc(k, g);
      in_valid = 1'b1;
      cycle(acc);
      chk("rt_accept", 32'(acc), 32'd1);
      if (k >= 1) begin
        for (int g = 0; g < 4; g++) begin
          chk("rt_idx", 32'(idx_a[g]), 32'(k - 1));
          chk("rt_err", 32'(err_a[g]), 32'd0);
          chk("rt_valid", 32'(ov_a[g]), 32'd1);
        end
      end
    end
    in_valid = 1'b0;
    cycle(acc);
    for (int g = 0; g < 4; g++) chk("rt_idx_last", 32'(idx_a[g]), 32'd15);
    drain(2);
    lat_chk = 1'b0;

    // Boundary and illegal patterns, each sent twice
    do_reset();
    out_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      mask_a[0] = 16'h00F5;
      mask_a[1] = 16'h00F5;
      mask_a[2] = 16'hFFFF;
      mask_a[3] = 16'h0000;
      in_valid = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      cycle(acc);
      chk("illegal_f5_idx", 32'(idx_a[0]), 32'd6);
      chk("illegal_f5_err", 32'(err_a[0]), 32'd1);
      chk("msb_ffff_idx", 32'(idx_a[2]), 32'd15);
      chk("msb_ffff_err", 32'(err_a[2]), 32'd1);
      chk("msb_0000_idx", 32'(idx_a[3]), 32'd0);
      chk("msb_0000_err", 32'(err_a[3]), 32'd1);
    end
    cycle(acc);
    chk("bound_cnt_ffff", 32'(cnt_a[2]), 32'd2);
    chk("bound_cnt_0000", 32'(cnt_a[3]), 32'd2);
    drain(2);

    // Backpressure: 8 words with a 5-cycle stall
    w = 0;
    it = 0;
    for (int g = 0; g < 4; g++) mask_a[g] = enc(int'($urandom_range(15)), g);
    while ((w < 8 || q.size() != 0) && it < 100) begin
      out_ready = !(it >= 3 && it < 8);
      in_valid = (w < 8);
      cycle(acc);
      if (acc) begin
        w++;
        for (int g = 0; g < 4; g++) mask_a[g] = enc(int'($urandom_range(15)), g);
      end
      it++;
    end
    chk("bp_sent", 32'(w), 32'd8);
    drain(2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      for (int g = 0; g < 4; g++)
        mask_a[g] = $urandom_range(1) ? enc(int'($urandom_range(15)), g) : 16'($urandom);
      cycle(acc);
    end
    drain(3);

    // Saturation: 300 illegal words
    do_reset();
    out_ready = 1'b1;
    w = 0;
    it = 0;
    while (w < 300 && it < 400) begin
      for (int g = 0; g < 4; g++) mask_a[g] = (16'($urandom) & ~16'h4002) | 16'h8001;
      in_valid = 1'b1;
      cycle(acc);
      if (acc) w++;
      it++;
    end
    drain(3);
    for (int g = 0; g < 4; g++) chk("saturated", 32'(cnt_a[g]), 32'd255);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int g = 0; g < 4; g++) mask_a[g] = 16'h8001;
    for (int i = 0; i < 3; i++) cycle(acc);
    chk("full_occupancy", 32'(q.size()), 32'd2);
    rst_n = 1'b0;
    cycle(acc);
    for (int g = 0; g < 4; g++) begin
      chk("midrst_valid", 32'(ov_a[g]), 32'd0);
      chk("midrst_cnt", 32'(cnt_a[g]), 32'd0);
    end
    rst_n = 1'b1;
    drain(6);
    for (int g = 0; g < 4; g++) chk("midrst_no_delivery", 32'(cnt_a[g]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mask_decode_16.md
MASK_DECODE_16 -- requirements
Module: mask_decode_16

Interface
REQ-001 Parameter FROM_MSB, default 1'b1: 1 means the thermometer ones fill from bit 15 downward; 0 means they fill from bit 0 upward.
REQ-002 Parameter DIAG_ONES, default 1'b1: 1 means index k is encoded as k+1 ones; 0 means index k is encoded as k ones.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset is synchronous and active-low.
REQ-005 Port in_mask, input, 16: thermometer mask to decode.
REQ-006 Port in_valid, input, 1: in_mask is valid this cycle.
REQ-007 Port in_ready, output, 1: the block accepts in_mask this cycle.
REQ-008 Port out_idx, output, 4: decoded index.
REQ-009 Port out_err, output, 1: the decoded word came from an illegal mask.
REQ-010 Port out_valid, output, 1: out_idx and out_err are valid.
REQ-011 Port out_ready, input, 1: the downstream consumer accepts the output this cycle.
REQ-012 Port err_count, output, 8: saturating count of delivered words with out_err=1.

Function
REQ-013 Legal mask, FROM_MSB=0: in_mask equals 2^n-1, where n is the number of ones (0..16).
REQ-014 Legal mask, FROM_MSB=1: the bit-reverse of in_mask is legal under REQ-013.
REQ-015 DIAG_ONES=0, decode: for a legal mask with n=0..15, out_idx=n and out_err=0.
REQ-016 DIAG_ONES=0, n=16: out_idx=15 and out_err=1.
REQ-017 DIAG_ONES=1, decode: for a legal mask with n=1..16, out_idx=n-1 and out_err=0.
REQ-018 DIAG_ONES=1, n=0: out_idx=0 and out_err=1.
REQ-019 Illegal mask: out_err=1; out_idx is the REQ-015..018 value computed from popcount(in_mask), saturated to the range 0..15.
REQ-020 The block SHALL be the exact inverse of the matching index-to-mask encoder: encode(k) followed by decode returns k with out_err=0, for all k=0..15.
REQ-021 Pipeline: two register stages; S1 captures in_mask, S2 holds out_idx, out_err and out_valid.
REQ-022 Stage enables: en2 = !v2 || out_ready; en1 = !v1 || en2; in_ready = en1 (combinational).
REQ-023 Input transfer occurs when in_valid && in_ready; S1 loads and v1 is set.
REQ-024 When en1 is high with no transfer, v1 is cleared.
REQ-025 When en2 is high, S2 loads the decode of S1 and v2 takes v1.
REQ-026 Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure.
REQ-027 Throughput: one word per cycle when out_ready is held high.
REQ-028 Stall: while out_valid && !out_ready, out_idx and out_err are held stable and no word is lost or duplicated.
REQ-029 Stall: with both stages full and out_ready=0, in_ready=0.
REQ-030 Simultaneous events: a word is accepted in the same cycle that S2 delivers and S1 forwards (full-rate streaming).
REQ-031 err_count increments by 1 on each output transfer (out_valid && out_ready) with out_err=1.
REQ-032 err_count saturates at 255 and does not wrap.
REQ-033 Output data is delivered in order; there is no reordering.

Reset
REQ-034 When rst_n=0 at a clock edge: v1=0, v2=0, out_valid=0, out_idx=0, out_err=0, err_count=0.
REQ-035 in_ready SHALL be 0 while rst_n=0.
REQ-036 Reset mid-operation discards every in-flight word; no output transfer occurs in the cycle after reset.
REQ-037 After rst_n returns to 1, in_ready=1 on the next cycle.

Verification
REQ-038 Round trip: for each parameter combination, drive the encoder pattern for k=0..15 back-to-back with out_ready=1 -> out_idx=k, out_err=0, 2-cycle latency, one result per cycle.
REQ-039 Boundaries: FROM_MSB=1, DIAG_ONES=1, in_mask=16'h0000 -> out_idx=0, out_err=1; FROM_MSB=1, DIAG_ONES=0, in_mask=16'hFFFF -> out_idx=15, out_err=1, err_count=2 after both are delivered.
REQ-040 Illegal pattern: FROM_MSB=0, DIAG_ONES=0, in_mask=16'h00F5 -> out_err=1, out_idx=6.
REQ-041 Backpressure: stream 8 words, hold out_ready=0 for 5 cycles -> in_ready=0 once 2 words are held, outputs stable, all 8 delivered in order once released.
REQ-042 Saturation: deliver 300 illegal words -> err_count=255.
REQ-043 Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 and err_count=0 next cycle, and none of the in-flight words is ever delivered.
